coco_sdram_arb: RTL and testbench
=================================

# coco_sdram_arb

Three-way arbiter that shares the single SDRAM controller request port between video fetch, CPU access and the ioctl loader. It sits between `coco3fpga`/loader logic and `sdram_32r8w` in the `CLK_114` domain. It serialises one transaction at a time, applies fixed priority (video > CPU > loader) with optional CPU anti-starvation, and watches each transaction with a watchdog.

## Interface
Parameters:
- `AW`, 25: address width.
- `TIMEOUT`, 64: cycles allowed from grant to `mem_ready` before abort; legal range 4..255.
- `STARVE_LIMIT`, 4: number of consecutive video grants with CPU pending before the CPU is forced to win; legal range 1..15.

Ports:
- `CLK`  in  1  clock (`CLK_114`)
- `RESET_N`  in  1  synchronous, active-low reset
- `vid_req`  in  1  video read request (level)
- `vid_addr`  in  AW  video read address
- `vid_ack`  out  1  one-cycle pulse: video request accepted downstream
- `vid_ready`  out  1  one-cycle pulse: video data valid on `arb_dout`
- `cpu_req`  in  1  CPU request (level)
- `cpu_rnw`  in  1  1 = read, 0 = write
- `cpu_addr`  in  AW  CPU address
- `cpu_din`  in  8  CPU write data
- `cpu_ack`  out  1  one-cycle pulse: CPU request accepted downstream
- `cpu_ready`  out  1  one-cycle pulse: CPU transaction complete
- `ld_req`  in  1  loader write request (level); loader is write-only
- `ld_addr`  in  AW  loader address
- `ld_din`  in  8  loader write data
- `ld_ack`  out  1  one-cycle pulse: loader request accepted downstream
- `ld_ready`  out  1  one-cycle pulse: loader write complete
- `mem_req`  out  1  request to the SDRAM controller
- `mem_rnw`  out  1  read/write select to the controller
- `mem_addr`  out  AW  address to the controller
- `mem_din`  out  8  write data to the controller
- `mem_ack`  in  1  controller accepted `mem_req`
- `mem_ready`  in  1  controller transaction done; `mem_dout` valid on this cycle
- `mem_dout`  in  16  controller read data
- `mem_busy`  in  1  controller busy (refresh/init); blocks new grants
- `arb_dout`  out  16  read data latched on `mem_ready`
- `grant`  out  2  current owner: 0 none, 1 video, 2 CPU, 3 loader
- `timeout`  out  1  one-cycle pulse when a transaction is aborted

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - Stays in IDLE while `mem_busy`=1.
  - Otherwise picks a winner: video, then CPU, then loader.
  - On a pick: latches the winner's addr/din/rnw into `mem_*` (video rnw=1, loader rnw=0), sets `grant`, and moves to ISSUE.
- **ISSUE**
  - Drives `mem_req`=1.
  - On `mem_ack`=1: drops `mem_req` on the next edge, pulses the owner's `*_ack` in the following cycle, and moves to WAIT.
  - If `mem_ack` and `mem_ready` arrive in the same cycle: pulses `*_ack` and goes directly to DONE.
- **WAIT**
  - On `mem_ready`=1: latches `arb_dout`<=`mem_dout` and moves to DONE.
- **DONE**
  - Pulses the owner's `*_ready` for exactly one cycle.
  - Clears `grant` to 0 and returns to IDLE.
  - DONE provides the one-cycle gap that lets a requester drop `req` before the next arbitration. A `req` still high in IDLE is treated as a new request.
- **Watchdog**
  - An 8-bit counter clears on entry to ISSUE and increments in ISSUE/WAIT.
  - When it reaches `TIMEOUT`-1, the block goes to DONE with `arb_dout`=16'hFFFF and pulses `timeout` together with `*_ready`.
  - If `*_ack` has not yet pulsed, it is not issued.
- `mem_ready` while in IDLE is ignored. `mem_ack` outside ISSUE is ignored.
- Requesters must hold addr/din/rnw stable from `req` until their `*_ready`. The arbiter latches them at grant and does not re-sample them.
- **Reset**
  - With `RESET_N`=0 at an edge: state becomes IDLE, all outputs 0 (including `arb_dout`=0 and `grant`=0), counters cleared.
  - An in-flight transaction is abandoned with no `*_ready`.

## Timing
- Cycle 0: IDLE sees `vid_req`.
- Cycle 1: ISSUE, `mem_req`=1.
- `mem_ack` seen at cycle k; `mem_req`=0 from cycle k+1.
- `vid_ack` pulses at cycle k+1.
- `mem_ready` at cycle m; DONE at cycle m+1 with `vid_ready`=1 and `arb_dout` valid.
- Cycle m+2: IDLE.
- Best-case turnaround with `mem_ack` and `mem_ready` in cycle 1: grant-to-ready 2 cycles; back-to-back grant period 4 cycles.
- All outputs are registered.
- `mem_busy` is sampled only in IDLE.

## Configuration
- `COCO_ARB_ANTISTARVE_EN` defined:
  - A 4-bit counter increments on each video grant made while `cpu_req`=1.
  - When the counter equals `STARVE_LIMIT`, the next IDLE arbitration grants the CPU even if `vid_req`=1, and the counter clears.
  - The counter also clears on any CPU grant.
- Not defined: strict priority, no counter logic, `STARVE_LIMIT` unused.

## Test plan
- Single CPU read to 25'h00FF00, controller acks at cycle 2 and returns 16'hA55A at cycle 5 -> `cpu_ack` pulses at cycle 3, `cpu_ready` at cycle 6, `arb_dout`=16'hA55A, `grant`=2 during cycles 1-5.
- `vid_req`, `cpu_req` and `ld_req` all high continuously -> grant order video, video, … with the loader never granted. With `COCO_ARB_ANTISTARVE_EN` and `STARVE_LIMIT`=4: V,V,V,V,C,V,V,V,V,C.
- `mem_busy`=1 for 10 cycles while `cpu_req`=1 -> `mem_req` stays 0 through those cycles; ISSUE starts the cycle after `mem_busy` falls.
- Controller never asserts `mem_ready`, `TIMEOUT`=64 -> `timeout` and `cpu_ready` pulse together 64 cycles after ISSUE entry; `arb_dout`=16'hFFFF; next arbitration proceeds normally.
- `RESET_N` low during WAIT of a loader write -> next cycle all outputs 0 and state IDLE. A late `mem_ready` in IDLE produces no `ld_ready`.
- Loader write to 25'h000010 with data 8'h3C while video and CPU are idle -> `mem_rnw`=0, `mem_addr`=25'h000010, `mem_din`=8'h3C; `ld_ack` then `ld_ready` pulse once each.

Source files
------------

// File: rtl/coco_sdram_arb_if.sv
// Bus bundle between coco_sdram_arb and its three requesters plus the SDRAM controller.
// The master modport is the arbiter's view; slave is the surrounding logic.
interface coco_sdram_arb_if #(
  parameter int AW = 25
);
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic          vid_ready;

  logic          cpu_req;
  logic          cpu_rnw;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic          cpu_ack;
  logic          cpu_ready;

  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_din;
  logic          ld_ack;
  logic          ld_ready;

  logic          mem_req;
  logic          mem_rnw;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_ack;
  logic          mem_ready;
  logic [15:0]   mem_dout;
  logic          mem_busy;

  logic [15:0]   arb_dout;
  logic [1:0]    grant;
  logic          timeout;

  modport master (
    input  vid_req, vid_addr, cpu_req, cpu_rnw, cpu_addr, cpu_din,
    input  ld_req, ld_addr, ld_din,
    input  mem_ack, mem_ready, mem_dout, mem_busy,
    output vid_ack, vid_ready, cpu_ack, cpu_ready, ld_ack, ld_ready,
    output mem_req, mem_rnw, mem_addr, mem_din,
    output arb_dout, grant, timeout
  );

  modport slave (
    output vid_req, vid_addr, cpu_req, cpu_rnw, cpu_addr, cpu_din,
    output ld_req, ld_addr, ld_din,
    output mem_ack, mem_ready, mem_dout, mem_busy,
    input  vid_ack, vid_ready, cpu_ack, cpu_ready, ld_ack, ld_ready,
    input  mem_req, mem_rnw, mem_addr, mem_din,
    input  arb_dout, grant, timeout
  );
endinterface

// File: rtl/coco_sdram_arb.sv
// Fixed-priority (video > CPU > loader) single-transaction SDRAM port arbiter with watchdog.
// Define COCO_ARB_ANTISTARVE_EN to force a CPU grant after STARVE_LIMIT video wins.
module coco_sdram_arb #(
  parameter int AW           = 25,
  parameter int TIMEOUT      = 64,
  parameter int STARVE_LIMIT = 4
) (
  input logic              CLK,
  input logic              RESET_N,
  coco_sdram_arb_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  if (TIMEOUT < 4 || TIMEOUT > 255) begin : g_bad_timeout
    $error("coco_sdram_arb: TIMEOUT must be within 4..255");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
    $error("coco_sdram_arb: STARVE_LIMIT must be within 1..15");
  end

  state_t        state;
  logic [7:0]    wd;
  logic [1:0]    grant_q;
  logic          mem_req_q;
  logic          mem_rnw_q;
  logic [AW-1:0] mem_addr_q;
  logic [7:0]    mem_din_q;
  logic [15:0]   arb_dout_q;
  logic [2:0]    ack_q;
  logic [2:0]    ready_q;
  logic          timeout_q;

  logic [1:0]    pick;
  logic [2:0]    owner;
  logic          force_cpu;

  // owner is one-hot {loader, cpu, video}, used to steer the ack/ready pulses
  assign owner = {grant_q == 2'd3, grant_q == 2'd2, grant_q == 2'd1};

  always_comb begin
    pick = 2'd0;
    if (force_cpu)         pick = 2'd2;
    else if (bus.vid_req)  pick = 2'd1;
    else if (bus.cpu_req)  pick = 2'd2;
    else if (bus.ld_req)   pick = 2'd3;
  end

`ifdef COCO_ARB_ANTISTARVE_EN
  logic [3:0] starve_cnt;

  assign force_cpu = bus.cpu_req && (starve_cnt == 4'(STARVE_LIMIT));

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      starve_cnt <= '0;
    end else if (state == IDLE && !bus.mem_busy) begin
      if (pick == 2'd2)
        starve_cnt <= '0;
      else if (pick == 2'd1 && bus.cpu_req)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign force_cpu = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state      <= IDLE;
      wd         <= '0;
      grant_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_rnw_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      arb_dout_q <= '0;
      ack_q      <= '0;
      ready_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      ack_q     <= '0;
      ready_q   <= '0;
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.mem_busy && pick != 2'd0) begin
            grant_q   <= pick;
            mem_req_q <= 1'b1;
            wd        <= '0;
            state     <= ISSUE;
            case (pick)
              2'd1: begin
                mem_rnw_q  <= 1'b1;
                mem_addr_q <= bus.vid_addr;
                mem_din_q  <= 8'h00;
              end
              2'd2: begin
                mem_rnw_q  <= bus.cpu_rnw;
                mem_addr_q <= bus.cpu_addr;
                mem_din_q  <= bus.cpu_din;
              end
              default: begin
                mem_rnw_q  <= 1'b0;
                mem_addr_q <= bus.ld_addr;
                mem_din_q  <= bus.ld_din;
              end
            endcase
          end
        end
        ISSUE: begin
          // Watchdog abort wins; an un-acked request never gets its ack pulse
          if (wd == WD_LAST) begin
            mem_req_q  <= 1'b0;
            arb_dout_q <= 16'hFFFF;
            ready_q    <= owner;
            timeout_q  <= 1'b1;
            grant_q    <= '0;
            state      <= DONE;
          end else begin
            wd <= wd + 8'd1;
            if (bus.mem_ack) begin
              mem_req_q <= 1'b0;
              ack_q     <= owner;
              if (bus.mem_ready) begin
                arb_dout_q <= bus.mem_dout;
                ready_q    <= owner;
                grant_q    <= '0;
                state      <= DONE;
              end else begin
                state <= WAIT;
              end
            end
          end
        end
        WAIT: begin
          if (wd == WD_LAST) begin
            arb_dout_q <= 16'hFFFF;
            ready_q    <= owner;
            timeout_q  <= 1'b1;
            grant_q    <= '0;
            state      <= DONE;
          end else begin
            wd <= wd + 8'd1;
            if (bus.mem_ready) begin
              arb_dout_q <= bus.mem_dout;
              ready_q    <= owner;
              grant_q    <= '0;
              state      <= DONE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.vid_ack   = ack_q[0];
  assign bus.cpu_ack   = ack_q[1];
  assign bus.ld_ack    = ack_q[2];
  assign bus.vid_ready = ready_q[0];
  assign bus.cpu_ready = ready_q[1];
  assign bus.ld_ready  = ready_q[2];
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_rnw   = mem_rnw_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.arb_dout  = arb_dout_q;
  assign bus.grant     = grant_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_coco_sdram_arb.sv
// Self-checking bench for coco_sdram_arb: directed vector table, corner-case sequences,
// and a randomized run checked against a transaction-level timing model.
module tb_coco_sdram_arb;

  localparam logic [24:0] CPU_A = 25'h00FF00;
  localparam logic [24:0] LD_A  = 25'h000010;
  localparam logic [24:0] VID_A = 25'h123456;

  typedef struct packed {
    logic [1:0]  grant;
    logic        mem_req;
    logic        mem_rnw;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din;
    logic [2:0]  acks;
    logic [2:0]  readys;
    logic        timeout;
    logic [15:0] arb_dout;
  } outs_t;

  typedef struct packed {
    logic        vid_req;
    logic        cpu_req;
    logic        ld_req;
    logic        mem_ack;
    logic        mem_ready;
    logic        mem_busy;
    logic [15:0] mem_dout;
  } ins_t;

  typedef struct {
    ins_t  in;
    outs_t exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  coco_sdram_arb_if #(.AW(25)) bus ();

  coco_sdram_arb #(.AW(25), .TIMEOUT(64), .STARVE_LIMIT(4)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  function automatic outs_t mo(logic [1:0] g, logic rq, logic rnw, logic [24:0] a, logic [7:0] d,
                               logic [2:0] ak, logic [2:0] rd, logic to, logic [15:0] dout);
    outs_t o;
    o.grant = g; o.mem_req = rq; o.mem_rnw = rnw; o.mem_addr = a; o.mem_din = d;
    o.acks = ak; o.readys = rd; o.timeout = to; o.arb_dout = dout;
    return o;
  endfunction

  function automatic ins_t mi(logic v, logic c, logic l, logic ak, logic rdy, logic busy,
                              logic [15:0] dout);
    ins_t s;
    s.vid_req = v; s.cpu_req = c; s.ld_req = l; s.mem_ack = ak; s.mem_ready = rdy;
    s.mem_busy = busy; s.mem_dout = dout;
    return s;
  endfunction

  function automatic outs_t sample();
    return mo(bus.grant, bus.mem_req, bus.mem_rnw, bus.mem_addr, bus.mem_din,
              {bus.ld_ack, bus.cpu_ack, bus.vid_ack},
              {bus.ld_ready, bus.cpu_ready, bus.vid_ready}, bus.timeout, bus.arb_dout);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input ins_t s);
    bus.vid_req   = s.vid_req;
    bus.cpu_req   = s.cpu_req;
    bus.ld_req    = s.ld_req;
    bus.mem_ack   = s.mem_ack;
    bus.mem_ready = s.mem_ready;
    bus.mem_busy  = s.mem_busy;
    bus.mem_dout  = s.mem_dout;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act = sample();
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  vec_t tbl [15];

`ifdef COCO_ARB_ANTISTARVE_EN
  int starve;
`endif

  initial begin
    outs_t o;
    vectors = 0;
    miscompares = 0;
`ifdef COCO_ARB_ANTISTARVE_EN
    starve = 0;
`endif

    // CPU read, loader write, then a video read completing in one ISSUE cycle
    tbl[0]  = '{mi(0,1,0,0,0,0,16'h0000),    mo(0,0,0,25'h0,8'h00,3'b000,3'b000,0,16'h0000)};
    tbl[1]  = '{mi(0,1,0,0,0,0,16'h0000),    mo(2,1,1,CPU_A,8'h77,3'b000,3'b000,0,16'h0000)};
    tbl[2]  = '{mi(0,1,0,1,0,0,16'h0000),    mo(2,1,1,CPU_A,8'h77,3'b000,3'b000,0,16'h0000)};
    tbl[3]  = '{mi(0,1,0,0,0,0,16'h0000),    mo(2,0,1,CPU_A,8'h77,3'b010,3'b000,0,16'h0000)};
    tbl[4]  = '{mi(0,1,0,0,0,0,16'h0000),    mo(2,0,1,CPU_A,8'h77,3'b000,3'b000,0,16'h0000)};
    tbl[5]  = '{mi(0,1,0,0,1,0,16'hA55A),    mo(2,0,1,CPU_A,8'h77,3'b000,3'b000,0,16'h0000)};
    tbl[6]  = '{mi(0,0,0,0,0,0,16'h0000),    mo(0,0,1,CPU_A,8'h77,3'b000,3'b010,0,16'hA55A)};
    tbl[7]  = '{mi(0,0,1,0,0,0,16'h0000),    mo(0,0,1,CPU_A,8'h77,3'b000,3'b000,0,16'hA55A)};
    tbl[8]  = '{mi(0,0,1,1,0,0,16'h0000),    mo(3,1,0,LD_A,8'h3C,3'b000,3'b000,0,16'hA55A)};
    tbl[9]  = '{mi(0,0,1,0,1,0,16'hBEEF),    mo(3,0,0,LD_A,8'h3C,3'b100,3'b000,0,16'hA55A)};
    tbl[10] = '{mi(0,0,0,0,0,0,16'h0000),    mo(0,0,0,LD_A,8'h3C,3'b000,3'b100,0,16'hBEEF)};
    tbl[11] = '{mi(1,0,0,0,0,0,16'h0000),    mo(0,0,0,LD_A,8'h3C,3'b000,3'b000,0,16'hBEEF)};
    tbl[12] = '{mi(1,0,0,1,1,0,16'h1234),    mo(1,1,1,VID_A,8'h00,3'b000,3'b000,0,16'hBEEF)};
    tbl[13] = '{mi(0,0,0,0,0,0,16'h0000),    mo(0,0,1,VID_A,8'h00,3'b001,3'b001,0,16'h1234)};
    tbl[14] = '{mi(0,0,0,0,0,0,16'h0000),    mo(0,0,1,VID_A,8'h00,3'b000,3'b000,0,16'h1234)};

    rst_n = 1'b0;
    applyStimulus(mi(0,0,0,0,0,0,16'h0000));
    bus.vid_addr = VID_A;
    bus.cpu_addr = CPU_A; bus.cpu_rnw = 1'b1; bus.cpu_din = 8'h77;
    bus.ld_addr  = LD_A;  bus.ld_din  = 8'h3C;
    tick();
    tick();
    checkOutput("reset", mo(0,0,0,25'h0,8'h00,3'b000,3'b000,0,16'h0000));
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      checkOutput($sformatf("table[%0d]", i), tbl[i].exp);
      applyStimulus(tbl[i].in);
      tick();
    end

    // All three requesters continuously high
    applyStimulus(mi(1,1,1,0,0,0,16'h0000));
    tick();
    for (int i = 0; i < 10; i++) begin
      int w;
      logic [1:0] want;
      w = 0;
      while (bus.grant == 2'd0 && w < 10) begin
        tick();
        w++;
      end
`ifdef COCO_ARB_ANTISTARVE_EN
      want = (i % 5 == 4) ? 2'd2 : 2'd1;
`else
      want = 2'd1;
`endif
      checkVal($sformatf("grant_order[%0d]", i), 64'(bus.grant), 64'(want));
      applyStimulus(mi(1,1,1,1,1,0,16'h0000));
      tick();
      applyStimulus(mi(1,1,1,0,0,0,16'h0000));
    end
    applyStimulus(mi(0,0,0,0,0,0,16'h0000));
    tick();
`ifdef COCO_ARB_ANTISTARVE_EN
    starve = 0;
`endif

    // mem_busy blocks arbitration for 10 cycles
    for (int c = 0; c < 10; c++) begin
      checkVal("busy_hold", 64'({bus.grant, bus.mem_req}), 64'(0));
      applyStimulus(mi(0,1,0,0,0,1,16'h0000));
      tick();
    end
    checkVal("busy_fall", 64'({bus.grant, bus.mem_req}), 64'(0));
    applyStimulus(mi(0,1,0,0,0,0,16'h0000));
    tick();
    checkVal("busy_issue", 64'({bus.grant, bus.mem_req}), 64'({2'd2, 1'b1}));
    applyStimulus(mi(0,1,0,1,1,0,16'h4321));
    tick();
    checkVal("busy_done", 64'({bus.cpu_ready, bus.arb_dout}), 64'({1'b1, 16'h4321}));
    applyStimulus(mi(0,0,0,0,0,0,16'h0000));
    tick();

    // Controller never responds: watchdog abort
    applyStimulus(mi(0,1,0,0,0,0,16'h0000));
    tick();
    for (int c = 1; c <= 64; c++) begin
      o = sample();
      checkVal($sformatf("watchdog_run[%0d]", c),
               64'({o.grant, o.mem_req, o.acks, o.readys, o.timeout}),
               64'({2'd2, 1'b1, 3'b000, 3'b000, 1'b0}));
      applyStimulus(mi(0,1,0,0,0,0,16'h0000));
      tick();
    end
    checkOutput("watchdog_abort", mo(0,0,1,CPU_A,8'h77,3'b000,3'b010,1,16'hFFFF));
    applyStimulus(mi(1,0,0,0,0,0,16'h0000));
    tick();
    checkVal("after_abort_idle", 64'({bus.grant, bus.timeout, bus.cpu_ready}), 64'(0));
    applyStimulus(mi(1,0,0,0,0,0,16'h0000));
    tick();
    checkVal("after_abort_issue", 64'({bus.grant, bus.mem_req}), 64'({2'd1, 1'b1}));
    applyStimulus(mi(1,0,0,1,1,0,16'h5678));
    tick();
    checkVal("after_abort_done", 64'({bus.vid_ready, bus.timeout, bus.arb_dout}),
             64'({1'b1, 1'b0, 16'h5678}));
    applyStimulus(mi(0,0,0,0,0,0,16'h0000));
    tick();

    // Reset while a loader write sits in WAIT, then a stale mem_ready
    applyStimulus(mi(0,0,1,0,0,0,16'h0000));
    tick();
    applyStimulus(mi(0,0,1,1,0,0,16'h0000));
    tick();
    checkVal("reset_wait_ack", 64'({bus.ld_ack, bus.grant}), 64'({1'b1, 2'd3}));
    applyStimulus(mi(0,0,1,0,0,0,16'h0000));
    tick();
    rst_n = 1'b0;
    tick();
    checkOutput("reset_in_wait", mo(0,0,0,25'h0,8'h00,3'b000,3'b000,0,16'h0000));
    rst_n = 1'b1;
    applyStimulus(mi(0,0,0,0,1,0,16'hABCD));
    tick();
    checkOutput("late_ready", mo(0,0,0,25'h0,8'h00,3'b000,3'b000,0,16'h0000));
    applyStimulus(mi(0,0,0,0,0,0,16'h0000));
    tick();

    // Randomized run against a transaction-level model of each grant
    begin : rand_phase
      logic [1:0]  win;
      int          t0, k, m, arb_at;
      bit          active, idle_now, busy_now;
      logic        rq_v, rq_c, rq_l;
      logic [15:0] rdata, dout_hold;
      logic        lat_rnw, nxt_rnw;
      logic [24:0] lat_addr, nxt_addr;
      logic [7:0]  lat_din, nxt_din;
      logic [2:0]  oh;
      outs_t       ex;
      active = 0; arb_at = 0; t0 = 0; k = 0; m = 0; win = 2'd0;
      rq_v = 0; rq_c = 0; rq_l = 0; rdata = '0; dout_hold = '0;
      lat_rnw = 0; lat_addr = '0; lat_din = '0;
      nxt_rnw = 0; nxt_addr = '0; nxt_din = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        oh = active ? 3'(1 << (int'(win) - 1)) : 3'b000;
        ex.grant    = (active && cyc > t0 && cyc <= m) ? win : 2'd0;
        ex.mem_req  = active && cyc > t0 && cyc <= k;
        ex.mem_rnw  = (active && cyc > t0) ? nxt_rnw  : lat_rnw;
        ex.mem_addr = (active && cyc > t0) ? nxt_addr : lat_addr;
        ex.mem_din  = (active && cyc > t0) ? nxt_din  : lat_din;
        ex.acks     = (active && cyc == k + 1) ? oh : 3'b000;
        ex.readys   = (active && cyc == m + 1) ? oh : 3'b000;
        ex.timeout  = 1'b0;
        ex.arb_dout = (active && cyc > m) ? rdata : dout_hold;
        checkOutput("random", ex);
        if (active && cyc == m + 1) begin
          active = 0;
          lat_rnw = nxt_rnw; lat_addr = nxt_addr; lat_din = nxt_din;
          dout_hold = rdata;
          arb_at = cyc + 1;
        end
        busy_now = ($urandom_range(4) == 0);
        idle_now = !active && cyc == arb_at;
        if (idle_now) begin
          rq_v = 1'($urandom); rq_c = 1'($urandom); rq_l = 1'($urandom);
          bus.vid_addr = 25'($urandom);
          bus.cpu_addr = 25'($urandom); bus.cpu_din = 8'($urandom); bus.cpu_rnw = 1'($urandom);
          bus.ld_addr  = 25'($urandom); bus.ld_din  = 8'($urandom);
          if (!busy_now && (rq_v || rq_c || rq_l)) begin
            win = rq_v ? 2'd1 : (rq_c ? 2'd2 : 2'd3);
`ifdef COCO_ARB_ANTISTARVE_EN
            if (rq_c && starve == 4) win = 2'd2;
            if (win == 2'd2) starve = 0;
            else if (win == 2'd1 && rq_c) starve++;
`endif
            case (win)
              2'd1:    begin nxt_rnw = 1'b1;        nxt_addr = bus.vid_addr; nxt_din = 8'h00;       end
              2'd2:    begin nxt_rnw = bus.cpu_rnw; nxt_addr = bus.cpu_addr; nxt_din = bus.cpu_din; end
              default: begin nxt_rnw = 1'b0;        nxt_addr = bus.ld_addr;  nxt_din = bus.ld_din;  end
            endcase
            t0 = cyc;
            k = cyc + int'($urandom_range(1, 4));
            m = k + int'($urandom_range(0, 5));
            rdata = 16'($urandom);
            active = 1;
          end else begin
            arb_at = cyc + 1;
          end
        end
        bus.vid_req  = rq_v;
        bus.cpu_req  = rq_c;
        bus.ld_req   = rq_l;
        bus.mem_busy = busy_now;
        bus.mem_ack  = (active && cyc == k) ||
                       ((idle_now || (active && cyc > k && cyc < m)) && ($urandom_range(1) == 1));
        bus.mem_ready = (active && cyc == m) || (idle_now && ($urandom_range(1) == 1));
        bus.mem_dout  = (active && cyc == m) ? rdata : 16'($urandom);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
